// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared constants, FSM encoding and digit-validity helper for the BCD subtractor.
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int BCD_MAX   = 9;
  localparam int BCD_RADIX = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SUB   = 3'd2,
    NEG   = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return digit <= DIGIT_W'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for bcd_serial_subtractor.
// The neg signal exists only when BCD_SIGNED_RESULT_EN is defined.
interface bcd_serial_subtractor_if
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
);

  logic                         start;
  logic [DIGIT_W*NDIGITS-1:0]   a;
  logic [DIGIT_W*NDIGITS-1:0]   b;
  logic                         borrow_in;
  logic                         busy;
  logic                         done;
  logic [DIGIT_W*NDIGITS-1:0]   diff;
  logic                         borrow_out;
  logic                         err;

`ifdef BCD_SIGNED_RESULT_EN
  logic                         neg;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, err, neg
  );
  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, err, neg
  );
`else
  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, err
  );
  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, err
  );
`endif

endinterface

// File: rtl/bcd_serial_subtractor_digit_sub.sv
// One-digit BCD subtractor: d = x - y - bin, with a ten's-complement fixup on borrow.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] t;

  // t spans -10..9 for valid digits, so its top bit is the sign
  always_comb begin
    t    = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bin};
    bout = t[DIGIT_W];
    d    = bout ? (t[DIGIT_W-1:0] + DIGIT_W'(BCD_RADIX)) : t[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor, LSD first, one digit per clock.
// BCD_SIGNED_RESULT_EN: negate negative results into sign-magnitude form.
module bcd_serial_subtractor
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_serial_subtractor_if.slave  bus
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last result
  // CHECK | validate every latched digit
  // SUB   | one digit of a - b - br per cycle
  // NEG   | one digit of 0 - diff per cycle (signed build only)
  // DONE  | done pulse, back to IDLE

  localparam int W     = DIGIT_W * NDIGITS;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       res_q, res_d;
  logic [W-1:0]       diff_q, diff_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               br_q, br_d;
  logic               borrow_out_q, borrow_out_d;
  logic               err_q, err_d;
`ifdef BCD_SIGNED_RESULT_EN
  logic               neg_q, neg_d;
`endif

  logic [DIGIT_W-1:0]   dig_d;
  logic                 dig_bout;
  logic                 bad_digit;
  logic [W+DIGIT_W-1:0] res_shift;

  bcd_digit_sub u_digit (
    .x    (a_q[DIGIT_W-1:0]),
    .y    (b_q[DIGIT_W-1:0]),
    .bin  (br_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!is_bcd(a_q[i*DIGIT_W +: DIGIT_W]) || !is_bcd(b_q[i*DIGIT_W +: DIGIT_W]))
        bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    diff_d       = diff_q;
    idx_d        = idx_q;
    br_d         = br_q;
    borrow_out_d = borrow_out_q;
    err_d        = err_q;
`ifdef BCD_SIGNED_RESULT_EN
    neg_d        = neg_q;
`endif
    res_shift    = {dig_d, res_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.borrow_in;
          err_d   = 1'b0;
`ifdef BCD_SIGNED_RESULT_EN
          neg_d   = 1'b0;
`endif
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (bad_digit) begin
          err_d        = 1'b1;
          diff_d       = '0;
          borrow_out_d = 1'b0;
          state_d      = DONE;
        end else begin
          idx_d   = '0;
          state_d = SUB;
        end
      end

      // SUB and NEG share the digit unit; NEG just runs with a = 0, b = diff
      SUB, NEG: begin
        a_d   = a_q >> DIGIT_W;
        b_d   = b_q >> DIGIT_W;
        res_d = res_shift[W+DIGIT_W-1:DIGIT_W];
        br_d  = dig_bout;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d = '0;
          if (state_q == SUB) begin
            borrow_out_d = dig_bout;
`ifdef BCD_SIGNED_RESULT_EN
            if (dig_bout) begin
              a_d     = '0;
              b_d     = res_d;
              br_d    = 1'b0;
              state_d = NEG;
            end else begin
              diff_d  = res_d;
              state_d = DONE;
            end
`else
            diff_d  = res_d;
            state_d = DONE;
`endif
          end else begin
            diff_d  = res_d;
`ifdef BCD_SIGNED_RESULT_EN
            neg_d   = |res_d;
`endif
            state_d = DONE;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      idx_q        <= '0;
      br_q         <= 1'b0;
      borrow_out_q <= 1'b0;
      err_q        <= 1'b0;
`ifdef BCD_SIGNED_RESULT_EN
      neg_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      idx_q        <= idx_d;
      br_q         <= br_d;
      borrow_out_q <= borrow_out_d;
      err_q        <= err_d;
`ifdef BCD_SIGNED_RESULT_EN
      neg_q        <= neg_d;
`endif
    end
  end

  assign bus.busy       = (state_q == CHECK) || (state_q == SUB) || (state_q == NEG);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_out_q;
  assign bus.err        = err_q;
`ifdef BCD_SIGNED_RESULT_EN
  assign bus.neg        = neg_q;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor (NDIGITS=4); honours BCD_SIGNED_RESULT_EN.
module tb_bcd_serial_subtractor;

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   miscompares;

  bcd_serial_subtractor_if #(.NDIGITS(4)) bus ();

  bcd_serial_subtractor #(.NDIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [15:0] diff;
    logic        bo;
    logic        err;
    logic        neg;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Latency = rising edges from the start-sampling edge up to the edge that samples done high
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff",       e.id, 32'(bus.diff),       32'(e.diff));
        check("borrow_out", e.id, 32'(bus.borrow_out), 32'(e.bo));
        check("err",        e.id, 32'(bus.err),        32'(e.err));
`ifdef BCD_SIGNED_RESULT_EN
        check("neg",        e.id, 32'(bus.neg),        32'(e.neg));
`endif
        check("latency",    e.id, 32'(cyc - e.t0 + 1), 32'(e.lat));
        check("busy_at_done", e.id, 32'(bus.busy),     32'd0);
      end
    end
  end

  task automatic issue(input int id, input logic [15:0] a, input logic [15:0] b, input logic bin);
    @(negedge clk);
    bus.a         = a;
    bus.b         = b;
    bus.borrow_in = bin;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int id);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout vec %0d: got no done expected done within 40 cycles", id);
      sb.delete();
    end
  endtask

  task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] ed, input logic ebo, input logic eerr, input logic eneg,
                        input int elat);
    exp_t e;
    issue(id, a, b, bin);
    e.id = id; e.diff = ed; e.bo = ebo; e.err = eerr; e.neg = eneg; e.lat = elat; e.t0 = cyc;
    sb.push_back(e);
    check("busy_after_start", id, 32'(bus.busy), 32'd1);
    wait_drain(id);
    repeat (2) @(negedge clk);
    check("diff_held", id, 32'(bus.diff), 32'(ed));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy",       0, 32'(bus.busy),       32'd0);
    check("rst_done",       0, 32'(bus.done),       32'd0);
    check("rst_diff",       0, 32'(bus.diff),       32'd0);
    check("rst_borrow_out", 0, 32'(bus.borrow_out), 32'd0);
    check("rst_err",        0, 32'(bus.err),        32'd0);
`ifdef BCD_SIGNED_RESULT_EN
    check("rst_neg",        0, 32'(bus.neg),        32'd0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(1, 16'h5432, 16'h1234, 1'b0, 16'h4198, 1'b0, 1'b0, 1'b0, 6);
    run_op(2, 16'h0100, 16'h0001, 1'b0, 16'h0099, 1'b0, 1'b0, 1'b0, 6);
    run_op(3, 16'h1000, 16'h0999, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 6);
`ifdef BCD_SIGNED_RESULT_EN
    run_op(4, 16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1, 10);
`else
    run_op(4, 16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b0, 6);
`endif

    // invalid digit, with a second start pulse while busy that must be ignored
    begin
      exp_t e;
      issue(5, 16'h12A4, 16'h0000, 1'b0);
      e.id = 5; e.diff = 16'h0000; e.bo = 1'b0; e.err = 1'b1; e.neg = 1'b0; e.lat = 2; e.t0 = cyc;
      sb.push_back(e);
      check("busy_after_start", 5, 32'(bus.busy), 32'd1);
      @(negedge clk);
      bus.a     = 16'h0009;
      bus.b     = 16'h0001;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_drain(5);
      repeat (12) @(negedge clk);
      check("err_held",  5, 32'(bus.err),  32'd1);
      check("diff_zero", 5, 32'(bus.diff), 32'd0);
      check("idle_busy", 5, 32'(bus.busy), 32'd0);
    end

    run_op(6, 16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0, 6);
`ifdef BCD_SIGNED_RESULT_EN
    run_op(7, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 10);
`else
    run_op(7, 16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 6);
`endif
    run_op(8, 16'h0345, 16'h00F0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2);
    run_op(9, 16'h9999, 16'h9999, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 6);
`ifdef BCD_SIGNED_RESULT_EN
    run_op(10, 16'h0500, 16'h0600, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1, 10);
`else
    run_op(10, 16'h0500, 16'h0600, 1'b0, 16'h9900, 1'b1, 1'b0, 1'b0, 6);
`endif

    // reset in the middle of SUB aborts the operation and clears the held result
    issue(11, 16'h5432, 16'h1234, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_busy",       11, 32'(bus.busy),       32'd0);
    check("midrst_done",       11, 32'(bus.done),       32'd0);
    check("midrst_diff",       11, 32'(bus.diff),       32'd0);
    check("midrst_borrow_out", 11, 32'(bus.borrow_out), 32'd0);
    check("midrst_err",        11, 32'(bus.err),        32'd0);
`ifdef BCD_SIGNED_RESULT_EN
    check("midrst_neg",        11, 32'(bus.neg),        32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(12, 16'h0009, 16'h0003, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0, 6);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
